// File: rtl/phase_dec_avg_pkg.sv
// Shared types and constants for the phase-noise decimating averager.
// Latency: none (declarations only).
// Backpressure: not applicable.
package phase_dec_avg_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } dec_state_t;

  localparam logic [1:0] FIFO_DEPTH = 2'd2;

endpackage

// File: rtl/dec_out_fifo.sv
// 2-entry result FIFO with a registered head entry; flush empties it.
// Latency: a push into an empty FIFO is visible at the head on the next cycle.
// Backpressure: a push when full with no pop is ignored; full and level report occupancy.
module dec_out_fifo
  import phase_dec_avg_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_dat,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_dat,
  output logic                  full,
  output logic                  empty,
  output logic [1:0]            level
);

  logic [DATA_WIDTH-1:0] e0;
  logic [DATA_WIDTH-1:0] e1;
  logic                  pop_ok;
  logic                  push_ok;

  assign full     = (level == FIFO_DEPTH);
  assign empty    = (level == 2'd0);
  assign head_dat = e0;
  assign pop_ok   = pop & ~empty;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  assign push_ok  = push & (~full | pop_ok);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      e0    <= '0;
      e1    <= '0;
      level <= 2'd0;
    end else if (flush) begin
      e0    <= '0;
      e1    <= '0;
      level <= 2'd0;
    end else if (push_ok && pop_ok) begin
      if (level == 2'd1) begin
        e0 <= push_dat;
      end else begin
        e0 <= e1;
        e1 <= push_dat;
      end
    end else if (push_ok) begin
      if (level == 2'd0) begin
        e0 <= push_dat;
      end else begin
        e1 <= push_dat;
      end
      level <= level + 2'd1;
    end else if (pop_ok) begin
      e0    <= e1;
      level <= level - 2'd1;
    end
  end

endmodule

// File: rtl/phase_dec_avg.sv
// Decimating averager: sums 2^DEC_LOG2 signed samples, emits the arithmetic-shift mean.
// Latency: result is valid the cycle after the edge capturing the window's last sample.
// Backpressure: 2-entry output FIFO; a result arriving when full is dropped and sets sticky ovf.
module phase_dec_avg
  import phase_dec_avg_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEC_LOG2   = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_vld,
  input  logic                  enable,
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_vld,
  input  logic                  data_out_rdy,
  output logic [1:0]            fill_lvl,
  output logic                  ovf
);

  localparam int ACC_WIDTH = DATA_WIDTH + DEC_LOG2;

  dec_state_t                   state;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic        [DEC_LOG2-1:0]   cnt;
  logic signed [ACC_WIDTH-1:0]  sum;
  logic        [DATA_WIDTH-1:0] result;
  logic                         take;
  logic                         last;
  logic                         push;
  logic                         pop;
  logic                         full;
  logic                         empty;

  assign sum    = acc + {{DEC_LOG2{data_in[DATA_WIDTH-1]}}, data_in};
  // Arithmetic shift floors toward -inf; the mean of N samples always fits DATA_WIDTH.
  assign result = DATA_WIDTH'(sum >>> DEC_LOG2);
  assign take   = (state == ST_ACCUM) & enable & data_in_vld;
  assign last   = &cnt;
  assign push   = take & last & ~clear;
  assign pop    = data_out_vld & data_out_rdy;

  assign data_out_vld = ~empty;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (enable) state <= ST_ACCUM;
        default: if (!enable) state <= ST_IDLE;
      endcase

      if (clear) begin
        acc <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end else begin
        if (!take) begin
          if (state == ST_IDLE || !enable) begin
            acc <= '0;
            cnt <= '0;
          end
        end else if (last) begin
          acc <= '0;
          cnt <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + DEC_LOG2'(1);
        end
        if (push && full && !pop) ovf <= 1'b1;
      end
    end
  end

  dec_out_fifo #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .flush    (clear),
    .push     (push),
    .push_dat (result),
    .pop      (pop),
    .head_dat (data_out),
    .full     (full),
    .empty    (empty),
    .level    (fill_lvl)
  );

endmodule

// File: tb/tb_phase_dec_avg.sv
// Directed bench for phase_dec_avg with N=4, 32-bit samples.
module tb_phase_dec_avg;

  logic        clk;
  logic        rstn;
  logic [31:0] data_in;
  logic        data_in_vld;
  logic        enable;
  logic        clear;
  logic [31:0] data_out;
  logic        data_out_vld;
  logic        data_out_rdy;
  logic [1:0]  fill_lvl;
  logic        ovf;

  int errors = 0;
  int checks = 0;

  phase_dec_avg #(
    .DATA_WIDTH(32),
    .DEC_LOG2  (2)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .data_in     (data_in),
    .data_in_vld (data_in_vld),
    .enable      (enable),
    .clear       (clear),
    .data_out    (data_out),
    .data_out_vld(data_out_vld),
    .data_out_rdy(data_out_rdy),
    .fill_lvl    (fill_lvl),
    .ovf         (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] v);
    data_in     = v;
    data_in_vld = 1'b1;
    step();
    data_in_vld = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; enable = 1'b0; clear = 1'b0; data_in = '0;
    data_in_vld = 1'b0; data_out_rdy = 1'b1;
    repeat (3) step();
    rstn = 1'b1;
    step();
    checks++; if (data_out !== 32'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", data_out); end
    checks++; if (data_out_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got=%b exp=0", data_out_vld); end
    checks++; if (fill_lvl !== 2'd0) begin errors++; $display("FAIL reset_fill got=%0d exp=0", fill_lvl); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
  endtask

  task automatic test_basic();
    enable = 1'b1; data_out_rdy = 1'b1;
    step();
    send(32'd1); send(32'd2); send(32'd3);
    checks++; if (data_out_vld !== 1'b0) begin errors++; $display("FAIL basic_early_vld got=%b exp=0", data_out_vld); end
    send(32'd6);
    checks++; if (data_out_vld !== 1'b1) begin errors++; $display("FAIL basic_vld got=%b exp=1", data_out_vld); end
    checks++; if (data_out !== 32'd3) begin errors++; $display("FAIL basic_data got=%0d exp=3", data_out); end
    step();
    checks++; if (data_out_vld !== 1'b0) begin errors++; $display("FAIL basic_vld_one_cycle got=%b exp=0", data_out_vld); end
    checks++; if (fill_lvl !== 2'd0) begin errors++; $display("FAIL basic_fill got=%0d exp=0", fill_lvl); end
  endtask

  task automatic test_signed();
    send(32'hFFFF_FFFF); send(32'hFFFF_FFFF); send(32'hFFFF_FFFF); send(32'hFFFF_FFFE);
    checks++; if (data_out !== 32'hFFFF_FFFE || data_out_vld !== 1'b1) begin
      errors++; $display("FAIL signed_floor got=%h vld=%b exp=fffffffe vld=1", data_out, data_out_vld); end
    step();
    repeat (4) send(32'h7FFF_FFFF);
    checks++; if (data_out !== 32'h7FFF_FFFF || data_out_vld !== 1'b1) begin
      errors++; $display("FAIL signed_max got=%h vld=%b exp=7fffffff vld=1", data_out, data_out_vld); end
    step();
  endtask

  task automatic test_backpressure();
    data_out_rdy = 1'b0;
    repeat (4) send(32'd4);
    checks++; if (fill_lvl !== 2'd1) begin errors++; $display("FAIL bp_fill1 got=%0d exp=1", fill_lvl); end
    repeat (4) send(32'd8);
    checks++; if (fill_lvl !== 2'd2) begin errors++; $display("FAIL bp_fill2 got=%0d exp=2", fill_lvl); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL bp_ovf_early got=%b exp=0", ovf); end
    repeat (4) send(32'd12);
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL bp_ovf got=%b exp=1", ovf); end
    checks++; if (data_out !== 32'd4 || fill_lvl !== 2'd2) begin
      errors++; $display("FAIL bp_hold got=%0d fill=%0d exp=4 fill=2", data_out, fill_lvl); end
    data_out_rdy = 1'b1;
    step();
    checks++; if (data_out !== 32'd8 || data_out_vld !== 1'b1) begin
      errors++; $display("FAIL bp_second got=%0d vld=%b exp=8 vld=1", data_out, data_out_vld); end
    step();
    checks++; if (data_out_vld !== 1'b0 || fill_lvl !== 2'd0) begin
      errors++; $display("FAIL bp_drained vld=%b fill=%0d exp vld=0 fill=0", data_out_vld, fill_lvl); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL bp_ovf_sticky got=%b exp=1", ovf); end
    clear = 1'b1; step(); clear = 1'b0;
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL bp_clear_ovf got=%b exp=0", ovf); end
  endtask

  task automatic test_push_pop_fill1();
    data_out_rdy = 1'b0;
    repeat (4) send(32'd4);
    send(32'd8); send(32'd8); send(32'd8);
    data_out_rdy = 1'b1;
    send(32'd8);
    checks++; if (fill_lvl !== 2'd1 || data_out !== 32'd8) begin
      errors++; $display("FAIL pushpop_fill1 fill=%0d data=%0d exp fill=1 data=8", fill_lvl, data_out); end
    step();
    checks++; if (data_out_vld !== 1'b0) begin errors++; $display("FAIL pushpop_drain got=%b exp=0", data_out_vld); end
  endtask

  task automatic test_enable_drop();
    send(32'd5); send(32'd5);
    enable = 1'b0; step();
    enable = 1'b1; step();
    send(32'd1); send(32'd1);
    checks++; if (data_out_vld !== 1'b0) begin errors++; $display("FAIL endrop_partial got=%b exp=0", data_out_vld); end
    send(32'd1);
    checks++; if (data_out_vld !== 1'b0) begin errors++; $display("FAIL endrop_third got=%b exp=0", data_out_vld); end
    send(32'd1);
    checks++; if (data_out !== 32'd1 || data_out_vld !== 1'b1) begin
      errors++; $display("FAIL endrop_result got=%0d vld=%b exp=1 vld=1", data_out, data_out_vld); end
    step();
  endtask

  task automatic test_gapped();
    for (int i = 0; i < 3; i++) begin
      send(32'd2);
      repeat (3) step();
    end
    checks++; if (data_out_vld !== 1'b0) begin errors++; $display("FAIL gap_early got=%b exp=0", data_out_vld); end
    send(32'd2);
    checks++; if (data_out !== 32'd2 || data_out_vld !== 1'b1) begin
      errors++; $display("FAIL gap_result got=%0d vld=%b exp=2 vld=1", data_out, data_out_vld); end
    step();
    checks++; if (data_out_vld !== 1'b0) begin errors++; $display("FAIL gap_single got=%b exp=0", data_out_vld); end
  endtask

  task automatic test_reset_mid();
    data_out_rdy = 1'b0;
    repeat (4) send(32'd3);
    send(32'd9); send(32'd9);
    checks++; if (fill_lvl !== 2'd1 || data_out !== 32'd3) begin
      errors++; $display("FAIL rstmid_pre fill=%0d data=%0d exp fill=1 data=3", fill_lvl, data_out); end
    #2 rstn = 1'b0;
    #1;
    checks++; if (data_out !== 32'd0 || data_out_vld !== 1'b0 || fill_lvl !== 2'd0 || ovf !== 1'b0) begin
      errors++; $display("FAIL rstmid_async data=%0d vld=%b fill=%0d ovf=%b exp all 0",
                         data_out, data_out_vld, fill_lvl, ovf); end
    #2 rstn = 1'b1;
    data_out_rdy = 1'b1;
    step(); step();
    send(32'd1); send(32'd1);
    checks++; if (data_out_vld !== 1'b0) begin errors++; $display("FAIL rstmid_discard got=%b exp=0", data_out_vld); end
    send(32'd1); send(32'd1);
    checks++; if (data_out !== 32'd1 || data_out_vld !== 1'b1) begin
      errors++; $display("FAIL rstmid_result got=%0d vld=%b exp=1 vld=1", data_out, data_out_vld); end
    step();
  endtask

  task automatic test_clear_same_cycle();
    send(32'd2); send(32'd2); send(32'd2);
    clear = 1'b1;
    send(32'd2);
    clear = 1'b0;
    checks++; if (data_out_vld !== 1'b0 || fill_lvl !== 2'd0) begin
      errors++; $display("FAIL clr_nopush vld=%b fill=%0d exp vld=0 fill=0", data_out_vld, fill_lvl); end
    send(32'd8);
    checks++; if (data_out_vld !== 1'b0) begin errors++; $display("FAIL clr_cnt0 got=%b exp=0", data_out_vld); end
    send(32'd8); send(32'd8); send(32'd8);
    checks++; if (data_out !== 32'd8 || data_out_vld !== 1'b1) begin
      errors++; $display("FAIL clr_after got=%0d vld=%b exp=8 vld=1", data_out, data_out_vld); end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_backpressure();
    test_push_pop_fill1();
    test_enable_drop();
    test_gapped();
    test_reset_mid();
    test_clear_same_cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
